// File: rtl/pipelined_mac_unit_if.sv
// Operand/result stream bundle for pipelined_mac_unit.
// Ports: slave side = MAC unit (consumes operand beats, produces results);
//        master side = producer of operands and consumer of results.
interface pipelined_mac_unit_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
);
  logic                 In_Valid;
  logic                 In_Ready;
  logic [WIDTH-1:0]     In_1;
  logic [WIDTH-1:0]     In_2;
  logic                 Sign;
  logic                 Mode;
  logic                 Acc_Clear;
  logic                 Acc_Last;
  logic                 Out_Valid;
  logic                 Out_Ready;
  logic [ACC_WIDTH-1:0] Result;
  logic                 Overflow;

  modport master (
    output In_Valid, In_1, In_2, Sign, Mode, Acc_Clear, Acc_Last, Out_Ready,
    input  In_Ready, Out_Valid, Result, Overflow
  );

  modport slave (
    input  In_Valid, In_1, In_2, Sign, Mode, Acc_Clear, Acc_Last, Out_Ready,
    output In_Ready, Out_Valid, Result, Overflow
  );
endinterface

// File: rtl/pipelined_mac_unit.sv
// Pipelined multiply-accumulate: WIDTHxWIDTH product or two-lane half-width dot product, summed into ACC_WIDTH.
// Latency: accepted Last beat -> Out_Valid MUL_STAGES+1 cycles later; one beat per cycle throughput.
// Backpressure: a held, unaccepted result freezes the whole pipe and drops In_Ready.
// Ports: Clk, Rst (sync, active-high); io = slave side of pipelined_mac_unit_if
//        (operand stream In_*/Sign/Mode/Acc_Clear/Acc_Last, result stream Out_Valid/Out_Ready/Result/Overflow).
module pipelined_mac_unit #(
  parameter int WIDTH      = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst,
  pipelined_mac_unit_if.slave io
);

  localparam int H = WIDTH / 2;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] prod;
    logic                 sign;
    logic                 clear;
    logic                 last;
    logic                 vld;
  } stage_t;

  // Widen a product of width n (n <= 2*WIDTH) to ACC_WIDTH, sign- or zero-filled.
  function automatic logic [ACC_WIDTH-1:0] ext_acc(input logic [2*WIDTH-1:0] v,
                                                  input int n, input logic msb,
                                                  input logic s);
    logic [ACC_WIDTH-1:0] keep;
    keep = (ACC_WIDTH'(1) << n) - ACC_WIDTH'(1);
    return (ACC_WIDTH'(v) & keep) | ((s && msb) ? ~keep : '0);
  endfunction

  logic stall;
  assign stall       = io.Out_Valid && !io.Out_Ready;
  assign io.In_Ready = !Rst && !stall;

  // Product generation. Operands get one extra bit carrying the sign (or a
  // zero for unsigned), so a single signed multiplier covers both modes and
  // -2^(W-1) * -2^(W-1) stays exact.
  logic signed [WIDTH:0]     op_a, op_b;
  logic signed [2*WIDTH-1:0] full_p;
  logic signed [H:0]         lo_a, lo_b, hi_a, hi_b;
  logic signed [WIDTH:0]     dot;
  logic [2*WIDTH-1:0]        raw;
  logic [ACC_WIDTH-1:0]      prod;

  always_comb begin
    op_a   = {io.Sign & io.In_1[WIDTH-1], io.In_1};
    op_b   = {io.Sign & io.In_2[WIDTH-1], io.In_2};
    full_p = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
    lo_a   = {io.Sign & io.In_1[H-1],     io.In_1[H-1:0]};
    lo_b   = {io.Sign & io.In_2[H-1],     io.In_2[H-1:0]};
    hi_a   = {io.Sign & io.In_1[WIDTH-1], io.In_1[WIDTH-1:H]};
    hi_b   = {io.Sign & io.In_2[WIDTH-1], io.In_2[WIDTH-1:H]};
    // Two lane products summed in WIDTH+1 bits: enough for the unsigned
    // maximum and the full signed range.
    dot    = (WIDTH+1)'(lo_a) * (WIDTH+1)'(lo_b) + (WIDTH+1)'(hi_a) * (WIDTH+1)'(hi_b);
    raw    = io.Mode ? (2*WIDTH)'($unsigned(dot)) : $unsigned(full_p);
    prod   = io.Mode ? ext_acc(raw, WIDTH + 1, dot[WIDTH], io.Sign)
                     : ext_acc(raw, 2 * WIDTH, full_p[2*WIDTH-1], io.Sign);
  end

  // Multiplier stages: shift only when the output is not blocked.
  stage_t stg [MUL_STAGES];
  stage_t tail;
  assign tail = stg[MUL_STAGES-1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < MUL_STAGES; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= '{prod: prod, sign: io.Sign, clear: io.Acc_Clear,
                  last: io.Acc_Last, vld: io.In_Valid && io.In_Ready};
      for (int i = 1; i < MUL_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  // Accumulate / output stage.
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_q, acc_next;
  logic                 ovf_q, ovf_next, add_ovf;

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, tail.prod};
    // Signed: operands agree in sign but the sum does not. Unsigned: carry out.
    if (tail.sign)
      add_ovf = (acc_q[ACC_WIDTH-1] == tail.prod[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    else
      add_ovf = sum[ACC_WIDTH];
    acc_next = tail.clear ? tail.prod : sum[ACC_WIDTH-1:0];
    ovf_next = tail.clear ? 1'b0 : (ovf_q | add_ovf);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      io.Out_Valid <= 1'b0;
      io.Result    <= '0;
      io.Overflow  <= 1'b0;
    end else if (!stall) begin
      if (tail.vld) begin
        acc_q <= acc_next;
        ovf_q <= ovf_next;
      end
      // A new result may replace the one being taken in the same cycle.
      if (tail.vld && tail.last) begin
        io.Out_Valid <= 1'b1;
        io.Result    <= acc_next;
        io.Overflow  <= ovf_next;
      end else if (io.Out_Ready) begin
        io.Out_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mac_unit.sv
// Directed + short random bench for pipelined_mac_unit: a 32-bit accumulator
// instance and a 17-bit instance (overflow and reset-mid-group cases),
// checked through per-instance expected-result queues.
module tb_pipelined_mac_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst17;
  logic [7:0] a_d, b_d;
  logic s_d, m_d, c_d, l_d, v0, v1, r0, r1;

  pipelined_mac_unit_if #(.WIDTH(8), .ACC_WIDTH(32)) bus ();
  pipelined_mac_unit_if #(.WIDTH(8), .ACC_WIDTH(17)) bus17 ();

  pipelined_mac_unit #(.WIDTH(8), .ACC_WIDTH(32), .MUL_STAGES(2)) dut (
    .Clk(clk), .Rst(rst), .io(bus));
  pipelined_mac_unit #(.WIDTH(8), .ACC_WIDTH(17), .MUL_STAGES(2)) dut17 (
    .Clk(clk), .Rst(rst17), .io(bus17));

  assign bus.In_1 = a_d;   assign bus.In_2 = b_d;   assign bus.Sign = s_d;
  assign bus.Mode = m_d;   assign bus.Acc_Clear = c_d; assign bus.Acc_Last = l_d;
  assign bus.In_Valid = v0; assign bus.Out_Ready = r0;
  assign bus17.In_1 = a_d; assign bus17.In_2 = b_d; assign bus17.Sign = s_d;
  assign bus17.Mode = m_d; assign bus17.Acc_Clear = c_d; assign bus17.Acc_Last = l_d;
  assign bus17.In_Valid = v1; assign bus17.Out_Ready = r1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int sx4(input logic [3:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic logic [31:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic s, input logic m);
    int va, vb, r;
    if (!m) begin
      va = s ? int'($signed(a)) : int'(a);
      vb = s ? int'($signed(b)) : int'(b);
      r  = va * vb;
    end else begin
      r = sx4(a[3:0], s) * sx4(b[3:0], s) + sx4(a[7:4], s) * sx4(b[7:4], s);
    end
    return 32'(r);
  endfunction

  // Result scoreboards: each handshake pops one expected entry.
  always @(negedge clk) begin
    if (bus.Out_Valid && bus.Out_Ready) begin
      exp_t e;
      check("out0_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("result0", 64'(bus.Result), 64'(e.res));
        check("overflow0", 64'(bus.Overflow), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (bus17.Out_Valid && bus17.Out_Ready) begin
      exp_t e;
      check("out17_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("result17", 64'(bus17.Result), 64'(e.res & 32'h1FFFF));
        check("overflow17", 64'(bus17.Overflow), 64'(e.ovf));
      end
    end
  end

  // Drives one beat (called at posedge+1) and returns once it is accepted.
  task automatic beat(input bit which, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic m, input logic c, input logic l,
                      input logic [31:0] er, input logic eo, input bit push);
    int   waitc;
    exp_t e;
    waitc = 0;
    if (push && l) begin
      e.res = er; e.ovf = eo;
      if (which) q1.push_back(e); else q0.push_back(e);
    end
    a_d = a; b_d = b; s_d = s; m_d = m; c_d = c; l_d = l;
    if (which) v1 = 1'b1; else v0 = 1'b1;
    while (!(which ? bus17.In_Ready : bus.In_Ready) && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    check("accept_timeout", 64'(waitc < 50), 64'd1);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("drain", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    exp_t        e;
    logic [7:0]  ra, rb;
    logic        rs, rm;

    a_d = '0; b_d = '0; s_d = 0; m_d = 0; c_d = 0; l_d = 0;
    v0 = 0; v1 = 0; r0 = 1; r1 = 1; rst = 1; rst17 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.Out_Valid), 64'd0);
    check("rst_result", 64'(bus.Result), 64'd0);
    check("rst_overflow", 64'(bus.Overflow), 64'd0);
    check("rst_in_ready", 64'(bus.In_Ready), 64'd0);
    check("rst17_in_ready", 64'(bus17.In_Ready), 64'd0);
    rst = 0; rst17 = 0;
    #1;
    check("in_ready_after_rst", 64'(bus.In_Ready), 64'd1);
    @(posedge clk); #1;

    // Unsigned 0xFF*0xFF with latency measurement.
    e.res = 32'h0000FE01; e.ovf = 1'b0; q0.push_back(e);
    a_d = 8'hFF; b_d = 8'hFF; s_d = 0; m_d = 0; c_d = 1; l_d = 1; v0 = 1;
    @(posedge clk); #1;
    v0 = 0; lat = 0;
    while (!bus.Out_Valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
    wait_drain();

    // Signed extremes, back to back.
    beat(0, 8'h80, 8'h80, 1, 0, 1, 1, 32'h00004000, 0, 1);
    beat(0, 8'h80, 8'h7F, 1, 0, 1, 1, 32'hFFFFC080, 0, 1);
    wait_drain();

    // Dual-lane, signed then unsigned.
    beat(0, 8'h8F, 8'h87, 1, 1, 1, 1, 32'd57, 0, 1);
    beat(0, 8'h8F, 8'h87, 0, 1, 1, 1, 32'd169, 0, 1);
    wait_drain();

    // Four-beat group: only the last beat produces output.
    beat(0, 8'd100, 8'd100, 0, 0, 1, 0, 0, 0, 0);
    beat(0, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0, 0);
    beat(0, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0, 0);
    beat(0, 8'd100, 8'd100, 0, 0, 0, 1, 32'd40000, 0, 1);
    wait_drain();

    // Bubble inside a group, then continuation past Last without Clear.
    beat(0, 8'd2, 8'd3, 0, 0, 1, 0, 0, 0, 0);
    idle(3);
    beat(0, 8'd4, 8'd5, 0, 0, 0, 1, 32'd26, 0, 1);
    beat(0, 8'd1, 8'd1, 0, 0, 0, 1, 32'd27, 0, 1);
    // Signed accumulate crossing zero: -16256 + 16129 = -127.
    beat(0, 8'h80, 8'h7F, 1, 0, 1, 0, 0, 0, 0);
    beat(0, 8'h7F, 8'h7F, 1, 0, 0, 1, 32'hFFFFFF81, 0, 1);
    wait_drain();

    // Backpressure with two groups in flight.
    r0 = 0;
    beat(0, 8'd3, 8'd4, 0, 0, 1, 1, 32'd12, 0, 1);
    beat(0, 8'd5, 8'd6, 0, 0, 1, 1, 32'd30, 0, 1);
    lat = 0;
    while (!bus.Out_Valid && lat < 20) begin @(negedge clk); lat++; end
    check("bp_out_valid", 64'(bus.Out_Valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.In_Ready), 64'd0);
      check("bp_result_hold", 64'(bus.Result), 64'd12);
      check("bp_valid_hold", 64'(bus.Out_Valid), 64'd1);
    end
    @(posedge clk); #1;
    r0 = 1;
    wait_drain();

    // Random single-beat groups against the reference product.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 1'($urandom); rm = 1'($urandom);
      beat(0, ra, rb, rs, rm, 1, 1, ref_prod(ra, rb, rs, rm), 0, 1);
    end
    wait_drain();

    // 17-bit accumulator: unsigned carry, then a fresh group clears it.
    beat(1, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
    beat(1, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    beat(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 32'd64003, 1, 1);
    beat(1, 8'd1, 8'd1, 0, 0, 1, 1, 32'd1, 0, 1);
    // Signed overflow: 4 * 16384 = 65536 exceeds the 17-bit signed range.
    beat(1, 8'h80, 8'h80, 1, 0, 1, 0, 0, 0, 0);
    beat(1, 8'h80, 8'h80, 1, 0, 0, 0, 0, 0, 0);
    beat(1, 8'h80, 8'h80, 1, 0, 0, 0, 0, 0, 0);
    beat(1, 8'h80, 8'h80, 1, 0, 0, 1, 32'h00010000, 1, 1);
    wait_drain();

    // Reset with a Last beat still in the pipe: it must never emerge.
    beat(1, 8'd2, 8'd2, 0, 0, 1, 0, 0, 0, 0);
    beat(1, 8'd3, 8'd3, 0, 0, 0, 1, 0, 0, 0);
    rst17 = 1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(bus17.Out_Valid), 64'd0);
    check("midrst_result", 64'(bus17.Result), 64'd0);
    check("midrst_overflow", 64'(bus17.Overflow), 64'd0);
    check("midrst_in_ready", 64'(bus17.In_Ready), 64'd0);
    rst17 = 0;
    idle(8);
    // Accumulator restarts from zero: a group without Clear yields 49.
    beat(1, 8'd7, 8'd7, 0, 0, 0, 1, 32'd49, 0, 1);
    wait_drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
